// File: rtl/pc_predict_unit_if.sv
// rtl/pc_predict_unit_if.sv - fetch/resolve bus between the pipeline and pc_predict_unit
interface pc_predict_unit_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic [WIDTH-1:0] pc;
  logic             pred_taken;
  logic [WIDTH-1:0] pred_target;
  logic             ex_valid;
  logic [WIDTH-1:0] ex_pc;
  logic             ex_is_branch;
  logic             ex_is_jump;
  logic             ex_taken;
  logic [WIDTH-1:0] ex_target;
  logic             ex_pred_taken;
  logic [WIDTH-1:0] ex_pred_target;
  logic             flush;

  modport master (
    output stall, ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_taken,
           ex_target, ex_pred_taken, ex_pred_target,
    input  pc, pred_taken, pred_target, flush
  );

  modport slave (
    input  stall, ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_taken,
           ex_target, ex_pred_taken, ex_pred_target,
    output pc, pred_taken, pred_target, flush
  );
endinterface

// File: rtl/pc_predict_unit.sv
// rtl/pc_predict_unit.sv - registered fetch PC with direct-mapped BTB (built when PC_PREDICT_BTB_EN is defined)
module pc_predict_unit #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 64,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000)
) (
  input logic              clk,
  input logic              rst,
  pc_predict_unit_if.slave bus
);
  localparam int IDX = $clog2(DEPTH);
  localparam int TW  = WIDTH - IDX - 2;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] ex_plus4;
  logic [WIDTH-1:0] next_pc;
  logic             pred_taken;
  logic [WIDTH-1:0] pred_target;
  logic             mispredict;

  assign pc_plus4 = pc_q + WIDTH'(4);
  assign ex_plus4 = bus.ex_pc + WIDTH'(4);

`ifdef PC_PREDICT_BTB_EN
  logic [DEPTH-1:0] btb_valid;
  logic [TW-1:0]    btb_tag    [DEPTH];
  logic [WIDTH-1:0] btb_target [DEPTH];
  logic [1:0]       btb_ctr    [DEPTH];

  logic [IDX-1:0]   rd_idx;
  logic [TW-1:0]    rd_tag;
  logic             rd_hit;
  logic [IDX-1:0]   wr_idx;
  logic [TW-1:0]    wr_tag;
  logic             wr_hit;
  logic             wr_en;

  // Lookup reads the table asynchronously, so a write lands on the next cycle's lookup
  assign rd_idx      = pc_q[IDX+1:2];
  assign rd_tag      = pc_q[WIDTH-1:IDX+2];
  assign rd_hit      = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
  assign pred_taken  = rd_hit && btb_ctr[rd_idx][1];
  assign pred_target = rd_hit ? btb_target[rd_idx] : pc_plus4;

  assign wr_idx = bus.ex_pc[IDX+1:2];
  assign wr_tag = bus.ex_pc[WIDTH-1:IDX+2];
  assign wr_hit = btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag);
  assign wr_en  = bus.ex_valid && (bus.ex_is_branch || bus.ex_is_jump);

  // Valid bits are the only reset table state; a taken miss allocates the entry
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid <= '0;
    end else if (wr_en && !wr_hit && bus.ex_taken) begin
      btb_valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/target/counter payload: train on hits, overwrite on taken misses
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      if (wr_hit) begin
        if (bus.ex_taken) begin
          btb_target[wr_idx] <= bus.ex_target;
          btb_ctr[wr_idx]    <= (btb_ctr[wr_idx] == 2'b11) ? 2'b11 : btb_ctr[wr_idx] + 2'd1;
        end else begin
          btb_ctr[wr_idx]    <= (btb_ctr[wr_idx] == 2'b00) ? 2'b00 : btb_ctr[wr_idx] - 2'd1;
        end
      end else if (bus.ex_taken) begin
        btb_tag[wr_idx]    <= wr_tag;
        btb_target[wr_idx] <= bus.ex_target;
        btb_ctr[wr_idx]    <= bus.ex_is_jump ? 2'b11 : 2'b10;
      end
    end
  end
`else
  // Static not-taken: the control-type flags only matter for table training
  logic unused_ctrl;
  assign unused_ctrl = &{1'b0, bus.ex_is_branch, bus.ex_is_jump};
  assign pred_taken  = 1'b0;
  assign pred_target = pc_plus4;
`endif

  // Full direction and target compare, also used when prediction is static
  assign mispredict = bus.ex_valid &&
                      ((bus.ex_taken != bus.ex_pred_taken) ||
                       (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));

  // Redirect beats stall so a resolving branch is never lost behind a fetch hold
  always_comb begin
    next_pc = pc_q;
    if (mispredict) begin
      next_pc = bus.ex_taken ? bus.ex_target : ex_plus4;
    end else if (!bus.stall) begin
      next_pc = pred_taken ? pred_target : pc_plus4;
    end
  end

  // Fetch PC register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= next_pc;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pred_taken  = pred_taken;
  assign bus.pred_target = pred_target;
  assign bus.flush       = mispredict && !rst;
endmodule
